// File: rtl/c_elem_pkg.sv
// Shared types and index helpers for the clocked C-element array.
//   mode_t  : per-channel join behaviour (symmetric, asymmetric-plus,
//             asymmetric-minus, reserved = symmetric)
//   mode_lsb: bit offset of channel k's mode field in the packed mode bus
//   in_lsb  : bit offset of channel k's first input in the packed input bus
package c_elem_pkg;

  typedef enum logic [1:0] {
    SYM    = 2'b00,
    APLUS  = 2'b01,
    AMINUS = 2'b10,
    RSVD   = 2'b11
  } mode_t;

  localparam int unsigned MODE_W = 2;

  function automatic int unsigned mode_lsb(input int unsigned chan);
    return chan * MODE_W;
  endfunction

  function automatic int unsigned in_lsb(input int unsigned chan, input int unsigned inputs);
    return chan * inputs;
  endfunction

endpackage

// File: rtl/c_elem_chan.sv
// One generalised Muller C-element channel.
//   clk      : clock
//   extReset : asynchronous active-low reset
//   en       : 1 lets c_o/toggle_o update; sync, filter and stall always run
//   mode     : join behaviour for this channel
//   in_i     : INPUTS asynchronous handshake wires
//   c_o      : registered C-element output
//   toggle_o : one-cycle pulse in the cycle c_o takes a new value
//   stall_o  : high while the filtered inputs have been mixed for TIMEOUT cycles
module c_elem_chan
  import c_elem_pkg::*;
#(
  parameter int unsigned INPUTS      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic              clk,
  input  logic              extReset,
  input  logic              en,
  input  mode_t             mode,
  input  logic [INPUTS-1:0] in_i,
  output logic              c_o,
  output logic              toggle_o,
  output logic              stall_o
);

  localparam int unsigned FCW = $clog2(FILTER + 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(FILTER - 1);
  localparam logic [FCW-1:0] F_ONE  = FCW'(1);

  logic [SYNC_STAGES-1:0][INPUTS-1:0] sync_q;
  logic [INPUTS-1:0]                  s;
  logic [INPUTS-1:0]                  f;
  logic [INPUTS-1:0][FCW-1:0]         fcnt;
  logic                               all1;
  logic                               all0;
  logic                               mixed;
  logic                               eval;

  // Synchroniser chain, stage 0 samples the raw asynchronous wires.
  always_ff @(posedge clk or negedge extReset) begin
    if (!extReset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Glitch filter: s must disagree with f for FILTER consecutive cycles.
  always_ff @(posedge clk or negedge extReset) begin
    if (!extReset) begin
      f    <= '0;
      fcnt <= '0;
    end else begin
      for (int unsigned j = 0; j < INPUTS; j++) begin
        if (s[j] == f[j]) begin
          fcnt[j] <= '0;
        end else if (fcnt[j] == F_LAST) begin
          f[j]    <= s[j];
          fcnt[j] <= '0;
        end else begin
          fcnt[j] <= fcnt[j] + F_ONE;
        end
      end
    end
  end

  assign all1  = &f;
  assign all0  = ~|f;
  assign mixed = !all1 && !all0;

  // Asymmetric modes let input 0 alone drive one of the two transitions.
  always_comb begin
    eval = c_o;
    case (mode)
      APLUS: begin
        if (all1)       eval = 1'b1;
        else if (!f[0]) eval = 1'b0;
      end
      AMINUS: begin
        if (f[0])       eval = 1'b1;
        else if (all0)  eval = 1'b0;
      end
      default: begin
        if (all1)       eval = 1'b1;
        else if (all0)  eval = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge extReset) begin
    if (!extReset) begin
      c_o      <= RESET_VAL;
      toggle_o <= 1'b0;
    end else if (en && (eval != c_o)) begin
      c_o      <= eval;
      toggle_o <= 1'b1;
    end else begin
      toggle_o <= 1'b0;
    end
  end

  if (TIMEOUT > 0) begin : g_stall
    localparam int unsigned SCW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] S_MAX = SCW'(TIMEOUT);
    localparam logic [SCW-1:0] S_ONE = SCW'(1);

    logic [SCW-1:0] scnt;

    always_ff @(posedge clk or negedge extReset) begin
      if (!extReset) begin
        scnt <= '0;
      end else if (mixed) begin
        if (scnt != S_MAX) scnt <= scnt + S_ONE;
      end else begin
        scnt <= '0;
      end
    end

    assign stall_o = (scnt == S_MAX);
  end else begin : g_no_stall
    assign stall_o = 1'b0;
  end

endmodule

// File: rtl/c_element_array.sv
// Clocked array of CHANNELS generalised Muller C-elements joining INPUTS
// asynchronous handshake wires each, with synchronisation, glitch filtering,
// transition pulses and a stall watchdog per channel.
//   clk      : clock
//   extReset : asynchronous active-low reset
//   en       : 1 lets outputs update; 0 freezes c_o and toggle_o
//   mode     : per-channel mode, channel k at [2k+1:2k]
//   in_i     : async inputs, channel k input j at bit k*INPUTS+j
//   c_o      : C-element outputs (registered)
//   toggle_o : one-cycle pulse when c_o[k] changes
//   stall_o  : channel k inputs mixed for >= TIMEOUT cycles
module c_element_array
  import c_elem_pkg::*;
#(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned INPUTS      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic                         clk,
  input  logic                         extReset,
  input  logic                         en,
  input  logic [MODE_W*CHANNELS-1:0]   mode,
  input  logic [INPUTS*CHANNELS-1:0]   in_i,
  output logic [CHANNELS-1:0]          c_o,
  output logic [CHANNELS-1:0]          toggle_o,
  output logic [CHANNELS-1:0]          stall_o
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    c_elem_chan #(
      .INPUTS      (INPUTS),
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER      (FILTER),
      .TIMEOUT     (TIMEOUT),
      .RESET_VAL   (RESET_VAL)
    ) u_chan (
      .clk      (clk),
      .extReset (extReset),
      .en       (en),
      .mode     (mode_t'(mode[mode_lsb(k) +: MODE_W])),
      .in_i     (in_i[in_lsb(k, INPUTS) +: INPUTS]),
      .c_o      (c_o[k]),
      .toggle_o (toggle_o[k]),
      .stall_o  (stall_o[k])
    );
  end

endmodule

// File: tb/tb_c_element_array.sv
module tb_c_element_array;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [5:0] mode;
  logic [5:0] in_v;
  logic [2:0] c_o;
  logic [2:0] toggle_o;
  logic [2:0] stall_o;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    int ch;
    bit val;
    int due;
  } exp_t;

  exp_t sb[$];

  c_element_array #(
    .CHANNELS    (3),
    .INPUTS      (2),
    .SYNC_STAGES (2),
    .FILTER      (2),
    .TIMEOUT     (64),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk      (clk),
    .extReset (rst_n),
    .en       (en),
    .mode     (mode),
    .in_i     (in_v),
    .c_o      (c_o),
    .toggle_o (toggle_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int ch, input int j, input bit v);
    in_v[ch*2+j] = v;
  endtask

  // Expected c_o change for channel ch to value v, lat edges after now.
  task automatic expect_chg(input int ch, input bit v, input int lat);
    exp_t e;
    e.ch  = ch;
    e.val = v;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // Monitor: every toggle pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (toggle_o[k]) begin
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_toggle: ch%0d toggled to %0d at cycle %0d, none expected",
                     k, c_o[k], cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.ch == k && e.val == c_o[k] && e.due == cyc) passes++;
            else $display("FAIL toggle_event: got ch%0d val %0d cycle %0d expected ch%0d val %0d cycle %0d",
                          k, c_o[k], cyc, e.ch, e.val, e.due);
          end
        end
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 6'b10_01_00;  // ch2 AMINUS, ch1 APLUS, ch0 SYM
    in_v  = '0;

    // 1. reset state and idle inputs
    tick(2);
    chk("reset_c_o", c_o, 0);
    chk("reset_toggle", toggle_o, 0);
    chk("reset_stall", stall_o, 0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_c_o", c_o, 0);

    // 2. SYM ch0 join
    set_in(0, 0, 1'b1);
    tick(10);
    set_in(0, 1, 1'b1);
    expect_chg(0, 1'b1, 5);
    tick(4);
    chk("sym_rise_not_early", c_o[0], 0);
    tick(1);
    chk("sym_rise", c_o[0], 1);
    tick(3);
    set_in(0, 0, 1'b0);
    tick(8);
    chk("sym_hold_high", c_o[0], 1);
    set_in(0, 1, 1'b0);
    expect_chg(0, 1'b0, 5);
    tick(8);
    chk("sym_fall", c_o[0], 0);

    // 3. glitch filter
    set_in(0, 0, 1'b1);
    tick(8);
    set_in(0, 1, 1'b1);
    tick(1);
    set_in(0, 1, 1'b0);
    tick(10);
    chk("glitch_rejected", c_o[0], 0);
    set_in(0, 1, 1'b1);
    expect_chg(0, 1'b1, 5);
    tick(2);
    set_in(0, 1, 1'b0);
    tick(10);
    chk("pulse_accepted_hold", c_o[0], 1);
    set_in(0, 0, 1'b0);
    expect_chg(0, 1'b0, 5);
    tick(8);

    // 4. APLUS ch1
    set_in(1, 0, 1'b1);
    set_in(1, 1, 1'b1);
    expect_chg(1, 1'b1, 5);
    tick(8);
    chk("aplus_rise", c_o[1], 1);
    set_in(1, 0, 1'b0);
    expect_chg(1, 1'b0, 5);
    tick(8);
    chk("aplus_fall_in0", c_o[1], 0);
    set_in(1, 1, 1'b0);
    tick(8);

    //    AMINUS ch2
    set_in(2, 0, 1'b1);
    expect_chg(2, 1'b1, 5);
    tick(8);
    chk("aminus_rise_in0", c_o[2], 1);
    set_in(2, 1, 1'b1);
    tick(8);
    set_in(2, 0, 1'b0);
    tick(8);
    chk("aminus_hold_high", c_o[2], 1);
    set_in(2, 1, 1'b0);
    expect_chg(2, 1'b0, 5);
    tick(8);
    chk("aminus_fall_all0", c_o[2], 0);

    // 5. stall watchdog on ch0
    set_in(0, 0, 1'b1);
    tick(67);
    chk("stall_not_early", stall_o[0], 0);
    tick(1);
    chk("stall_rise", stall_o[0], 1);
    tick(20);
    chk("stall_saturated", stall_o[0], 1);
    chk("stall_other_ch", stall_o[2:1], 0);
    set_in(0, 1, 1'b1);
    expect_chg(0, 1'b1, 5);
    tick(4);
    chk("stall_hold_until_uniform", stall_o[0], 1);
    tick(1);
    chk("stall_clear", stall_o[0], 0);
    chk("stall_c_o", c_o[0], 1);
    set_in(0, 0, 1'b0);
    set_in(0, 1, 1'b0);
    expect_chg(0, 1'b0, 5);
    tick(8);

    // 6. enable gating, then async reset mid-filter
    en = 1'b0;
    set_in(0, 0, 1'b1);
    set_in(0, 1, 1'b1);
    tick(10);
    chk("en_low_held", c_o[0], 0);
    en = 1'b1;
    expect_chg(0, 1'b1, 1);
    tick(1);
    chk("en_high_update", c_o[0], 1);
    tick(2);
    set_in(0, 0, 1'b0);
    set_in(0, 1, 1'b0);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_c_o", c_o, 0);
    chk("async_reset_toggle", toggle_o, 0);
    chk("async_reset_stall", stall_o, 0);
    #1;
    rst_n = 1'b1;
    tick(10);
    chk("post_reset_idle", c_o, 0);

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      tick(1);
      t++;
    end
    chk("queue_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
